// File: rtl/demo_timing_seq_pkg.sv
// Shared timing defaults, scene FSM encoding and the registered video-output bundle
// for the demo timing sequencer.
package demo_timing_seq_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Counter / coordinate width; 10 bits covers both 800 and 525.
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } scene_state_e;

  typedef struct packed {
    logic             hsync_n;
    logic             vsync_n;
    logic             de;
    logic             frame_start;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } vid_out_t;

  localparam vid_out_t VID_IDLE = '{
    hsync_n:     1'b1,
    vsync_n:     1'b1,
    de:          1'b0,
    frame_start: 1'b0,
    x:           '0,
    y:           '0
  };

  // True when v lies in the half-open window [lo, lo+len).
  function automatic logic in_win(input logic [CNT_W-1:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/demo_sync_counter.sv
// Horizontal/vertical raster counters with registered sync, de and coordinate decode.
// Counters and outputs freeze/idle while run is low.
module demo_sync_counter
  import demo_timing_seq_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     run,
  output logic     frame_end,
  output vid_out_t vid
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT_N = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_N = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  vid_out_t         vid_q, vid_d;
  logic             line_end;

  always_comb begin
    line_end  = (hcnt_q == H_LAST);
    frame_end = line_end && (vcnt_q == V_LAST);
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    vid_d     = VID_IDLE;
    if (run) begin
      hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
      if (line_end) vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;

      // Outputs describe the current counter state, one clock later.
      vid_d.de          = (hcnt_q < H_ACT_N) && (vcnt_q < V_ACT_N);
      vid_d.x           = vid_d.de ? hcnt_q : '0;
      vid_d.y           = vid_d.de ? vcnt_q : '0;
      vid_d.hsync_n     = !in_win(hcnt_q, H_ACTIVE + H_FP, H_SYNC);
      vid_d.vsync_n     = !in_win(vcnt_q, V_ACTIVE + V_FP, V_SYNC);
      vid_d.frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      vid_q  <= VID_IDLE;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      vid_q  <= vid_d;
    end
  end

  assign vid = vid_q;

endmodule

// File: rtl/demo_timing_seq.sv
// Demo timing sequencer: VGA-style raster timing plus a scene/frame sequencer
// with hold, manual scene advance and an ena-controlled freeze.
module demo_timing_seq
  import demo_timing_seq_pkg::*;
#(
  parameter int  H_ACTIVE         = H_ACTIVE_DEF,
  parameter int  H_FP             = H_FP_DEF,
  parameter int  H_SYNC           = H_SYNC_DEF,
  parameter int  H_BP             = H_BP_DEF,
  parameter int  V_ACTIVE         = V_ACTIVE_DEF,
  parameter int  V_FP             = V_FP_DEF,
  parameter int  V_SYNC           = V_SYNC_DEF,
  parameter int  V_BP             = V_BP_DEF,
  parameter int  FRAMES_PER_SCENE = 256,
  parameter int  NUM_SCENES       = 4,
  localparam int SC_W             = $clog2(NUM_SCENES),
  localparam int FC_W             = $clog2(FRAMES_PER_SCENE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             hold,
  input  logic             next_req,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic [SC_W-1:0]  scene,
  output logic [FC_W-1:0]  frame_cnt
);

  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SCENE - 1);

  scene_state_e    state_q, state_d;
  logic [SC_W-1:0] scene_q, scene_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            pend_q, pend_d;
  logic            active, frame_end, boundary;
  vid_out_t        vid;

  // ena/hold are acted on in the same cycle they are seen, so the state
  // entered on this edge (state_d) is what governs counting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ena) state_d = hold ? ST_HOLD : ST_RUN;
      ST_RUN: begin
        if (!ena)     state_d = ST_IDLE;
        else if (hold) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!ena)      state_d = ST_IDLE;
        else if (!hold) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign active   = (state_d != ST_IDLE);
  assign boundary = active && frame_end;

  always_comb begin
    scene_d = scene_q;
    fc_d    = fc_q;
    pend_d  = pend_q;
    if (!active) begin
      pend_d = 1'b0;
    end else if (boundary) begin
      pend_d = 1'b0;
      // A manual request absorbs any coincident auto-advance: one step only.
      if (pend_q || next_req) begin
        scene_d = scene_q + 1'b1;
        fc_d    = '0;
      end else if (state_d == ST_RUN) begin
        if (fc_q == FC_LAST) begin
          fc_d    = '0;
          scene_d = scene_q + 1'b1;
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end
    end else if (next_req) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      scene_q <= '0;
      fc_q    <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scene_q <= scene_d;
      fc_q    <= fc_d;
      pend_q  <= pend_d;
    end
  end

  demo_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (active),
    .frame_end (frame_end),
    .vid       (vid)
  );

  assign hsync       = vid.hsync_n;
  assign vsync       = vid.vsync_n;
  assign de          = vid.de;
  assign x           = vid.x;
  assign y           = vid.y;
  assign frame_start = vid.frame_start;
  assign scene       = scene_q;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_demo_timing_seq.sv
// Bench for demo_timing_seq on a shrunken raster: vector table, directed corner
// sequences and randomized run checked each cycle against a linear-position model.
module tb_demo_timing_seq;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int FPS = 4, NS = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, ena = 1'b1, hold = 1'b0, next_req = 1'b0;
  logic       hsync, vsync, de, frame_start;
  logic [9:0] x, y;
  logic [1:0] scene, frame_cnt;

  demo_timing_seq #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FRAMES_PER_SCENE(FPS), .NUM_SCENES(NS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .hold(hold), .next_req(next_req),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .scene(scene), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r, e, h, n;
    bit hs, vs, de, fs;
    int x, y, sc, fc;
  } vec_t;

  vec_t tv[8];
  int   n_chk = 0, n_fail = 0, cyc = 0;

  // Reference model: position within the frame as one linear index.
  int m_pos = 0, m_fc = 0, m_sc = 0;
  bit m_pend = 0;
  bit e_hs = 1, e_vs = 1, e_de = 0, e_fs = 0;
  int e_x = 0, e_y = 0;

  int fs_c[$], sc_l[$], fc_l[$];
  int hs_lo = 0, vs_lo = 0, de_n = 0, hold_fs = 0, fc_moved = 0, bad = 0;
  logic [1:0] fc0;
  logic [27:0] got_v, want_v;
  bit r_e = 1, r_h = 0;

  function automatic vec_t mk(bit r, bit e, bit h, bit n, bit hs, bit vs, bit d, bit fs,
                              int xx, int yy, int sc, int fc);
    vec_t v;
    v.r = r; v.e = e; v.h = h; v.n = n; v.hs = hs; v.vs = vs; v.de = d; v.fs = fs;
    v.x = xx; v.y = yy; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit h, input bit n);
    int hh, vv;
    if (!r) begin
      m_pos = 0; m_fc = 0; m_sc = 0; m_pend = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_x = 0; e_y = 0;
    end else if (!e) begin
      m_pend = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_x = 0; e_y = 0;
    end else begin
      hh = m_pos % HT;
      vv = m_pos / HT;
      e_de = (hh < HA) && (vv < VA);
      e_x  = e_de ? hh : 0;
      e_y  = e_de ? vv : 0;
      e_hs = !(hh >= HA + HFP && hh < HA + HFP + HS);
      e_vs = !(vv >= VA + VFP && vv < VA + VFP + VS);
      e_fs = (m_pos == 0);
      if (m_pos == FRAME - 1) begin
        if (m_pend || n) begin
          m_sc = (m_sc + 1) % NS;
          m_fc = 0;
        end else if (!h) begin
          m_fc++;
          if (m_fc == FPS) begin
            m_fc = 0;
            m_sc = (m_sc + 1) % NS;
          end
        end
        m_pend = 0;
      end else if (n) begin
        m_pend = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic chk_model();
    n_chk++;
    if (hsync !== e_hs || vsync !== e_vs || de !== e_de || frame_start !== e_fs ||
        x !== 10'(e_x) || y !== 10'(e_y) || scene !== 2'(m_sc) || frame_cnt !== 2'(m_fc)) begin
      n_fail++;
      $display("FAIL model cycle %0d: got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d sc=%0d fc=%0d expected hs=%b vs=%b de=%b fs=%b x=%0d y=%0d sc=%0d fc=%0d",
               cyc, hsync, vsync, de, frame_start, x, y, scene, frame_cnt,
               e_hs, e_vs, e_de, e_fs, e_x, e_y, m_sc, m_fc);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit h, input bit n);
    rst_n = r; ena = e; hold = h; next_req = n;
    @(posedge clk);
    model(r, e, h, n);
    #1;
    cyc++;
    chk_model();
  endtask

  task automatic wait_fs();
    bit got = 0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      step(1, 1, 0, 0);
      got = frame_start;
    end
    if (!got) chk("frame_start_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    tv[0] = mk(0,1,0,0, 1,1,0,0, 0,0,0,0);
    tv[1] = mk(1,1,0,0, 1,1,1,1, 0,0,0,0);
    tv[2] = mk(1,1,0,0, 1,1,1,0, 1,0,0,0);
    tv[3] = mk(1,0,0,0, 1,1,0,0, 0,0,0,0);
    tv[4] = mk(1,0,0,1, 1,1,0,0, 0,0,0,0);
    tv[5] = mk(1,1,0,0, 1,1,1,0, 2,0,0,0);
    tv[6] = mk(1,1,1,0, 1,1,1,0, 3,0,0,0);
    tv[7] = mk(1,1,0,0, 1,1,1,0, 4,0,0,0);
    #3;
    for (int i = 0; i < 8; i++) begin
      step(tv[i].r, tv[i].e, tv[i].h, tv[i].n);
      got_v  = {hsync, vsync, de, frame_start, x, y, scene, frame_cnt};
      want_v = {tv[i].hs, tv[i].vs, tv[i].de, tv[i].fs, 10'(tv[i].x), 10'(tv[i].y),
                2'(tv[i].sc), 2'(tv[i].fc)};
      chk($sformatf("vec%0d", i), int'(got_v), int'(want_v));
    end

    // Nine frames from reset: period, sync widths, scene/frame sequence.
    step(0, 1, 0, 0);
    for (int c = 0; c < 8 * FRAME + 1; c++) begin
      step(1, 1, 0, 0);
      if (frame_start) begin
        fs_c.push_back(c);
        sc_l.push_back(int'(scene));
        fc_l.push_back(int'(frame_cnt));
      end
      if (c < 2 * FRAME) begin
        if (!hsync) hs_lo++;
        if (!vsync) vs_lo++;
        if (de) de_n++;
      end
    end
    chk("fs_count", fs_c.size(), 9);
    if (fs_c.size() >= 2) chk("fs_period", fs_c[1] - fs_c[0], FRAME);
    for (int k = 0; k < fs_c.size() && k < 9; k++) begin
      chk($sformatf("scene_at_frame%0d", k), sc_l[k], k / FPS);
      chk($sformatf("fc_at_frame%0d", k), fc_l[k], k % FPS);
    end
    chk("hsync_low_2frames", hs_lo, 2 * VT * HS);
    chk("vsync_low_2frames", vs_lo, 2 * VS * HT);
    chk("de_count_2frames", de_n, 2 * HA * VA);

    // Manual advance from scene 3 frame 2 wraps scene to 0.
    for (int i = 0; i < 12 && !(scene == 2'd3 && frame_cnt == 2'd2); i++) wait_fs();
    chk("reach_s3_f2", int'({scene, frame_cnt}), 14);
    repeat (20) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    wait_fs();
    chk("nreq_scene_wrap", int'(scene), 0);
    chk("nreq_fc_clear", int'(frame_cnt), 0);
    repeat (3) wait_fs();
    chk("reach_fc3", int'({scene, frame_cnt}), 3);
    repeat (20) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    wait_fs();
    chk("coincident_scene", int'(scene), 1);
    chk("coincident_fc", int'(frame_cnt), 0);

    // Hold for three frames: frame_start keeps pulsing, frame_cnt frozen.
    fc0 = frame_cnt;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1, 1, 1, 0);
      if (frame_start) hold_fs++;
      if (frame_cnt != fc0) fc_moved++;
    end
    chk("hold_fs_pulses", hold_fs, 3);
    chk("hold_fc_changes", fc_moved, 0);

    // ena low for 1000 clocks mid-line, then resume at the next pixel.
    for (int i = 0; i < 2 * FRAME && m_pos != 2 * HT + 5; i++) step(1, 1, 0, 0);
    chk("pre_freeze_x", int'(x), 4);
    chk("pre_freeze_y", int'(y), 2);
    for (int i = 0; i < 1000; i++) begin
      step(1, 0, 0, 0);
      if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0 || frame_start !== 1'b0 ||
          x !== 10'd0 || y !== 10'd0) bad++;
    end
    chk("idle_output_cycles", bad, 0);
    step(1, 1, 0, 0);
    chk("resume_x", int'(x), 5);
    chk("resume_y", int'(y), 2);
    chk("resume_de", int'(de), 1);

    // Mid-frame reset with every other input active.
    for (int i = 0; i < 2 * FRAME && m_pos != 5 * HT + 10; i++) step(1, 1, 0, 0);
    step(0, 1, 1, 1);
    chk("rst_sync_de_fs", int'({hsync, vsync, de, frame_start}), 12);
    chk("rst_xy", int'({x, y}), 0);
    chk("rst_scene", int'(scene), 0);
    chk("rst_fc", int'(frame_cnt), 0);
    step(1, 1, 0, 0);
    chk("post_rst_fs", int'(frame_start), 1);
    chk("post_rst_de", int'(de), 1);
    chk("post_rst_xy", int'({x, y}), 0);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) == 0) r_e = !r_e;
      if ($urandom_range(199) == 0) r_h = !r_h;
      step($urandom_range(799) != 0, r_e, r_h, $urandom_range(149) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demo_timing_seq.md
DEMO_TIMING_SEQ -- requirements
Module: demo_timing_seq

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have these parameters: H_ACTIVE 640, visible pixels/line; H_FP 16, H_SYNC 96, H_BP 48, horizontal porches/sync in clocks; V_ACTIVE 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33, vertical porches/sync in lines; FRAMES_PER_SCENE 256, frames per scene; NUM_SCENES 4, scene count (power of two).
Ports (name, direction, width, meaning):
REQ-002 clk  input  1  single clock, pixel rate (25.2 MHz nominal).
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  design selected; low = freeze.
REQ-005 hold  input  1  level; freezes frame/scene advancement.
REQ-006 next_req  input  1  one-clock pulse; request scene advance.
REQ-007 hsync, vsync  output  1 each  sync, active-low.
REQ-008 de  output  1  active-video enable.
REQ-009 x, y  output  10 each  pixel coordinates, valid while de=1.
REQ-010 frame_start  output  1  one-clock pulse at pixel (0,0).
REQ-011 scene  output  2 (log2 NUM_SCENES)  current scene index.
REQ-012 frame_cnt  output  8 (log2 FRAMES_PER_SCENE)  frame within scene.

Function
REQ-013 hcnt SHALL count 0..H_TOTAL-1 (800) and wrap to 0; vcnt SHALL increment on hcnt wrap, counting 0..V_TOTAL-1 (525), then wrap to 0.
REQ-014 All outputs SHALL be registered, with one clock of latency from counter state; x, y, de, hsync and vsync SHALL be mutually cycle-aligned.
REQ-015 hsync SHALL be 0 iff hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]; vsync SHALL be 0 iff vcnt is in [490,491].
REQ-016 de SHALL be 1 iff hcnt<640 and vcnt<480; x=hcnt and y=vcnt when de=1, and x and y SHALL be 0 when de=0.
REQ-017 frame_start SHALL pulse for exactly one clock, aligned with the output for hcnt=0, vcnt=0.
REQ-018 Scene FSM states: IDLE (ena=0), RUN, HOLD; transitions: IDLE->RUN when ena=1; RUN<->HOLD following the hold level; any state->IDLE when ena=0.
REQ-019 In RUN, at each frame boundary (vcnt=524 and hcnt=799 wrap), frame_cnt SHALL increment; at FRAMES_PER_SCENE-1 it SHALL wrap to 0 and scene SHALL increment.
REQ-020 A next_req pulse in RUN or HOLD SHALL be latched as pending; at the next frame boundary the block SHALL advance scene by one, set frame_cnt to 0, and clear pending.
REQ-021 If auto-advance and pending next_req fall on the same boundary, scene SHALL advance by exactly one.
REQ-022 scene SHALL wrap from NUM_SCENES-1 to 0.
REQ-023 In HOLD, timing counters SHALL run and frame_cnt SHALL freeze; a pending next_req is still honoured at the boundary.
REQ-024 In IDLE, all counters SHALL freeze and outputs SHALL idle: hsync=1, vsync=1, de=0, frame_start=0, x=y=0; the pending flag SHALL be cleared.
REQ-025 On ena rising, timing SHALL resume from the frozen hcnt/vcnt values (no re-phase).

Reset
REQ-026 When rst_n=0 at a clk edge, the block SHALL set hcnt=vcnt=0, frame_cnt=0, scene=0, pending=0 and the FSM to IDLE.
REQ-027 Reset output values SHALL be hsync=1, vsync=1, de=0, x=y=0, frame_start=0.
REQ-028 Reset asserted mid-frame SHALL take effect on that edge, regardless of ena, hold or next_req.
REQ-029 The first cycle after reset release with ena=1 SHALL present pixel (0,0) with frame_start=1 on the following clock.

Structure
REQ-030 The shared package SHALL hold the timing defaults (H_*/V_* constants, H_TOTAL, V_TOTAL) and the scene FSM state enum.
REQ-031 One sub-module, demo_sync_counter (hcnt/vcnt with wrap and sync/de decode), SHALL be instantiated; the scene FSM SHALL reside in the top.

Verification
REQ-032 Reset release, ena=1, run 2 frames -> frame_start period 420000 clocks; hsync low 96 clocks/line; vsync low 1600 clocks/frame.
REQ-033 Sample at first clock after frame_start: de=1, x=0, y=0; at x=639 the next clock has de=0; y=479 is the last active line.
REQ-034 FRAMES_PER_SCENE=4 with 9 frames -> scene sequence 0,0,0,0,1,1,1,1,2; frame_cnt wraps 3->0.
REQ-035 next_req at frame 2 of scene 3 -> scene=0, frame_cnt=0 at the next boundary; next_req coincident with auto-advance -> single increment.
REQ-036 hold=1 for 3 frames -> frame_cnt constant, frame_start still pulses; ena=0 for 1000 clocks mid-line -> outputs idle, resume at same hcnt.
REQ-037 rst_n=0 for one clock at hcnt=700, vcnt=300 -> next outputs show reset values; scene=0.
